// File: rtl/regf_bist_if.sv
// Register-file port bundle shared by regf_bist (master) and the lab 2 RegFile (slave).
interface regf_bist_if #(
  parameter int DW = 4,
  parameter int AW = 5
);
  logic          io_write_en;
  logic [AW-1:0] io_write_addr;
  logic [DW-1:0] io_write_data;
  logic [AW-1:0] io_read_addr1;
  logic [AW-1:0] io_read_addr2;
  logic [DW-1:0] io_read_data1;
  logic [DW-1:0] io_read_data2;

  modport master (
    output io_write_en, io_write_addr, io_write_data, io_read_addr1, io_read_addr2,
    input  io_read_data1, io_read_data2
  );

  modport slave (
    input  io_write_en, io_write_addr, io_write_data, io_read_addr1, io_read_addr2,
    output io_read_data1, io_read_data2
  );
endinterface

// File: rtl/regf_bist.sv
// Write/read-back BIST for the lab 2 RegFile: true then inverted pattern, dual-port compare.
// Optional build macro REGF_BIST_X0_EN: address 0 is expected to read back as zero.
module regf_bist #(
  parameter int DW = 4,
  parameter int AW = 5,
  parameter int EW = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_start,
  input  logic [DW-1:0]  io_seed,
  regf_bist_if.master    rf,
  output logic           io_busy,
  output logic           io_done,
  output logic           io_pass,
  output logic [EW-1:0]  io_err_count,
  output logic           io_fail_valid,
  output logic [AW-1:0]  io_fail_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        state;
  logic          inv;
  logic [AW-1:0] i;
  logic [DW-1:0] seed;
  logic          mis1;
  logic          mis2;
  logic [EW-1:0] err_next;

  function automatic logic [DW-1:0] pat_fn(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return DW'(a) + s;
  endfunction

  function automatic logic [DW-1:0] exp_fn(input logic [AW-1:0] a, input logic [DW-1:0] s,
                                           input logic p);
    return p ? ~pat_fn(a, s) : pat_fn(a, s);
  endfunction

  function automatic logic [DW-1:0] chk_fn(input logic [AW-1:0] a, input logic [DW-1:0] s,
                                           input logic p);
`ifdef REGF_BIST_X0_EN
    if (a == '0) return '0;
`endif
    return exp_fn(a, s, p);
  endfunction

  function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] cnt, input logic [1:0] inc);
    logic [EW:0] sum;
    sum = {1'b0, cnt} + (EW+1)'(inc);
    return sum[EW] ? '1 : sum[EW-1:0];
  endfunction

  // Compare stage: read data arrives combinationally for the addresses presented this cycle
  always_comb begin
    mis1     = (state == READ) && (rf.io_read_data1 != chk_fn(rf.io_read_addr1, seed, inv));
    mis2     = (state == READ) && (rf.io_read_data2 != chk_fn(rf.io_read_addr2, seed, inv));
    err_next = sat_add(io_err_count, {1'b0, mis1} + {1'b0, mis2});
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && io_start) seed <= io_seed;
  end

  // Sequencer: every output is registered one cycle ahead of the step it drives
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      inv              <= 1'b0;
      i                <= '0;
      rf.io_write_en   <= 1'b0;
      rf.io_write_addr <= '0;
      rf.io_write_data <= '0;
      rf.io_read_addr1 <= '0;
      rf.io_read_addr2 <= '0;
      io_busy          <= 1'b0;
      io_done          <= 1'b0;
      io_pass          <= 1'b0;
      io_err_count     <= '0;
      io_fail_valid    <= 1'b0;
      io_fail_addr     <= '0;
    end else begin
      io_done <= 1'b0;
      case (state)
        IDLE: begin
          if (io_start) begin
            state            <= WRITE;
            inv              <= 1'b0;
            i                <= '0;
            io_busy          <= 1'b1;
            rf.io_write_en   <= 1'b1;
            rf.io_write_addr <= '0;
            rf.io_write_data <= pat_fn('0, io_seed);
            io_pass          <= 1'b0;
            io_err_count     <= '0;
            io_fail_valid    <= 1'b0;
            io_fail_addr     <= '0;
          end
        end
        WRITE: begin
          if (i == LAST) begin
            state            <= READ;
            i                <= '0;
            rf.io_write_en   <= 1'b0;
            rf.io_read_addr1 <= '0;
            rf.io_read_addr2 <= LAST;
          end else begin
            i                <= i + 1'b1;
            rf.io_write_addr <= i + 1'b1;
            rf.io_write_data <= exp_fn(i + 1'b1, seed, inv);
          end
        end
        READ: begin
          io_err_count <= err_next;
          if ((mis1 || mis2) && !io_fail_valid) begin
            io_fail_valid <= 1'b1;
            io_fail_addr  <= mis1 ? rf.io_read_addr1 : rf.io_read_addr2;
          end
          if (i == LAST) begin
            i <= '0;
            if (!inv) begin
              state            <= WRITE;
              inv              <= 1'b1;
              rf.io_write_en   <= 1'b1;
              rf.io_write_addr <= '0;
              rf.io_write_data <= exp_fn('0, seed, 1'b1);
            end else begin
              state   <= DONE;
              io_busy <= 1'b0;
              io_done <= 1'b1;
              io_pass <= (err_next == '0);
            end
          end else begin
            i                <= i + 1'b1;
            rf.io_read_addr1 <= i + 1'b1;
            rf.io_read_addr2 <= LAST - (i + 1'b1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
